// File: rtl/convex_pkg.sv
// Shared types, constants and helpers for the CONVEX sequencing controller.
package convex_pkg;

  localparam int unsigned MAXPT   = 12;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned NIB_W   = 5;
  localparam int unsigned NIB_CNT = 4;
  localparam int unsigned RADDR_W = 4;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_LD0,
    ST_LD1,
    ST_LD2,
    ST_LD3,
    ST_ISSUE,
    ST_WAIT,
    ST_DROP,
    ST_COMMIT
  } ctrl_state_e;

  // Index of the lowest set bit of a drop mask (0 when the mask is empty).
  function automatic logic [RADDR_W-1:0] lsb_idx(input logic [MAXPT-1:0] m);
    logic [RADDR_W-1:0] idx;
    idx = '0;
    for (int i = int'(MAXPT) - 1; i >= 0; i--) begin
      if (m[i]) idx = RADDR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/convex_pt_deser.sv
// Four-nibble point assembly register: X = {n0, n1}, Y = {n2, n3}.
module convex_pt_deser
  import convex_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_en,
  input  logic [1:0]         nib_idx,
  input  logic [NIB_W-1:0]   nib,
  output point_t             pt
);

  logic [NIB_CNT-1:0][NIB_W-1:0] nib_q;
  logic [NIB_CNT-1:0][NIB_W-1:0] nib_d;

  // Overwrite the selected nibble slot when the FSM enables a load.
  always_comb begin
    nib_d = nib_q;
    if (ld_en) nib_d[nib_idx] = nib;
  end

  // Nibble storage; a reset discards any partial point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) nib_q <= '0;
    else        nib_q <= nib_d;
  end

  assign pt = {nib_q[0], nib_q[1], nib_q[2], nib_q[3]};

endmodule

// File: rtl/convex_ctrl.sv
// CONVEX sequencing controller: fetches points over the nibble stream, offers
// them to the hull core, serialises the drop result and commits the update.
// DROP_X/DROP_Y pass the combinational hull read data straight through during
// mask-mode drop cycles so each dropped entry appears in the cycle its index
// is presented; otherwise they show a held register.
module convex_ctrl
  import convex_pkg::*;
(
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NIB_W-1:0]   PT_XY,
  output logic               READ_PT,
  output logic [COORD_W-1:0] PT_X,
  output logic [COORD_W-1:0] PT_Y,
  output logic               PT_VALID,
  input  logic               PT_READY,
  input  logic               RES_VALID,
  input  logic               RES_INSIDE,
  input  logic [MAXPT-1:0]   RES_MASK,
  output logic [RADDR_W-1:0] HULL_RADDR,
  input  logic [COORD_W-1:0] HULL_X,
  input  logic [COORD_W-1:0] HULL_Y,
  output logic               COMMIT,
  output logic [COORD_W-1:0] DROP_X,
  output logic [COORD_W-1:0] DROP_Y,
  output logic               DROP_V
);

  ctrl_state_e        state_q, state_d;
  logic               read_pt_q, read_pt_d;
  logic               pt_valid_q, pt_valid_d;
  logic               commit_q, commit_d;
  logic               drop_v_q, drop_v_d;
  logic               inside_q, inside_d;
  logic [MAXPT-1:0]   mask_q, mask_d;
  logic [MAXPT-1:0]   mask_clr;
  logic [RADDR_W-1:0] hull_raddr_q, hull_raddr_d;
  point_t             drop_hold_q, drop_hold_d;

  logic               ld_en;
  logic [1:0]         nib_idx;
  point_t             pt;

  convex_pt_deser u_deser (
    .clk     (CLK),
    .rst_n   (RST_N),
    .ld_en   (ld_en),
    .nib_idx (nib_idx),
    .nib     (PT_XY),
    .pt      (pt)
  );

  // Next-state, datapath updates and registered output intents.
  always_comb begin
    state_d      = state_q;
    inside_d     = inside_q;
    mask_d       = mask_q;
    hull_raddr_d = hull_raddr_q;
    drop_hold_d  = drop_hold_q;
    ld_en        = 1'b0;
    nib_idx      = 2'd0;
    mask_clr     = mask_q & ~(MAXPT'(1) << hull_raddr_q);

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ:  state_d = ST_LD0;
      ST_LD0: begin
        ld_en   = 1'b1;
        nib_idx = 2'd0;
        state_d = ST_LD1;
      end
      ST_LD1: begin
        ld_en   = 1'b1;
        nib_idx = 2'd1;
        state_d = ST_LD2;
      end
      ST_LD2: begin
        ld_en   = 1'b1;
        nib_idx = 2'd2;
        state_d = ST_LD3;
      end
      ST_LD3: begin
        ld_en   = 1'b1;
        nib_idx = 2'd3;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (PT_READY) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (RES_VALID) begin
          inside_d = RES_INSIDE;
          if (RES_INSIDE) begin
            mask_d      = '0;
            drop_hold_d = pt;
            state_d     = ST_DROP;
          end else if (RES_MASK == '0) begin
            mask_d  = '0;
            state_d = ST_COMMIT;
          end else begin
            mask_d       = RES_MASK;
            hull_raddr_d = lsb_idx(RES_MASK);
            state_d      = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (inside_q) begin
          state_d = ST_COMMIT;
        end else begin
          mask_d      = mask_clr;
          drop_hold_d = '{x: HULL_X, y: HULL_Y};
          if (mask_clr != '0) hull_raddr_d = lsb_idx(mask_clr);
          else                state_d      = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        inside_d = 1'b0;
        mask_d   = '0;
        state_d  = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    read_pt_d  = (state_d == ST_REQ);
    pt_valid_d = (state_d == ST_ISSUE);
    commit_d   = (state_d == ST_COMMIT);
    drop_v_d   = (state_d == ST_DROP);
  end

  // State and output registers; reset abandons any point in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      read_pt_q    <= 1'b0;
      pt_valid_q   <= 1'b0;
      commit_q     <= 1'b0;
      drop_v_q     <= 1'b0;
      inside_q     <= 1'b0;
      mask_q       <= '0;
      hull_raddr_q <= '0;
      drop_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      read_pt_q    <= read_pt_d;
      pt_valid_q   <= pt_valid_d;
      commit_q     <= commit_d;
      drop_v_q     <= drop_v_d;
      inside_q     <= inside_d;
      mask_q       <= mask_d;
      hull_raddr_q <= hull_raddr_d;
      drop_hold_q  <= drop_hold_d;
    end
  end

  assign READ_PT    = read_pt_q;
  assign PT_VALID   = pt_valid_q;
  assign COMMIT     = commit_q;
  assign DROP_V     = drop_v_q;
  assign HULL_RADDR = hull_raddr_q;
  assign PT_X       = pt.x;
  assign PT_Y       = pt.y;
  assign DROP_X     = (drop_v_q && !inside_q) ? HULL_X : drop_hold_q.x;
  assign DROP_Y     = (drop_v_q && !inside_q) ? HULL_Y : drop_hold_q.y;

endmodule

// File: tb/tb_convex_ctrl.sv
// Directed self-checking bench for convex_ctrl.
module tb_convex_ctrl;
  import convex_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [NIB_W-1:0]   pt_xy;
  logic               read_pt;
  logic [COORD_W-1:0] pt_x, pt_y;
  logic               pt_valid;
  logic               pt_ready;
  logic               res_valid;
  logic               res_inside;
  logic [MAXPT-1:0]   res_mask;
  logic [RADDR_W-1:0] hull_raddr;
  logic [COORD_W-1:0] hull_x, hull_y;
  logic               commit;
  logic [COORD_W-1:0] drop_x, drop_y;
  logic               drop_v;

  logic [COORD_W-1:0] hx [16];
  logic [COORD_W-1:0] hy [16];

  int errors = 0;
  int checks = 0;
  int rp_cnt = 0;
  int rp_consec = 0;
  int commit_cnt = 0;
  logic rp_prev = 1'b0;

  convex_ctrl dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .PT_XY      (pt_xy),
    .READ_PT    (read_pt),
    .PT_X       (pt_x),
    .PT_Y       (pt_y),
    .PT_VALID   (pt_valid),
    .PT_READY   (pt_ready),
    .RES_VALID  (res_valid),
    .RES_INSIDE (res_inside),
    .RES_MASK   (res_mask),
    .HULL_RADDR (hull_raddr),
    .HULL_X     (hull_x),
    .HULL_Y     (hull_y),
    .COMMIT     (commit),
    .DROP_X     (drop_x),
    .DROP_Y     (drop_y),
    .DROP_V     (drop_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational hull storage model.
  assign hull_x = hx[hull_raddr];
  assign hull_y = hy[hull_raddr];

  // Handshake activity counters.
  always @(posedge clk) begin
    if (read_pt) rp_cnt++;
    if (read_pt && rp_prev) rp_consec++;
    rp_prev = read_pt;
    if (commit) commit_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the REQ cycle; returns in the first ISSUE cycle.
  task automatic feed(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    step(); pt_xy = x[9:5];
    step(); pt_xy = x[4:0];
    step(); pt_xy = y[9:5];
    step(); pt_xy = y[4:0];
    step(); pt_xy = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      hx[i] = '0;
      hy[i] = '0;
    end
    hx[0] = 10'd1;  hy[0] = 10'd2;
    hx[1] = 10'd3;  hy[1] = 10'd4;
    hx[2] = 10'd10; hy[2] = 10'd20;
    hx[5] = 10'd30; hy[5] = 10'd40;
    hx[11] = 10'd50; hy[11] = 10'd60;

    rst_n = 1'b0; pt_xy = '0; pt_ready = 1'b0;
    res_valid = 1'b0; res_inside = 1'b0; res_mask = '0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_read_pt",  32'(read_pt), 0);
    check("rst_pt_valid", 32'(pt_valid), 0);
    check("rst_commit",   32'(commit), 0);
    check("rst_drop_v",   32'(drop_v), 0);
    check("rst_pt_x",     32'(pt_x), 0);
    check("rst_pt_y",     32'(pt_y), 0);
    check("rst_drop_x",   32'(drop_x), 0);
    check("rst_drop_y",   32'(drop_y), 0);
    check("rst_raddr",    32'(hull_raddr), 0);

    rst_n = 1'b1;
    check("idle_read_pt", 32'(read_pt), 0);
    step();
    check("req1_read_pt", 32'(read_pt), 1);

    // Point (992,31) with backpressure and a spurious result pulse.
    feed(10'd992, 10'd31);
    check("asm_valid", 32'(pt_valid), 1);
    check("asm_x", 32'(pt_x), 992);
    check("asm_y", 32'(pt_y), 31);
    check("asm_read_pt", 32'(read_pt), 0);
    for (int i = 2; i <= 5; i++) begin
      res_valid  = (i == 3);
      res_inside = (i == 3);
      res_mask   = (i == 3) ? 12'hFFF : 12'h000;
      step();
      check("bp_valid", 32'(pt_valid), 1);
      check("bp_x", 32'(pt_x), 992);
      check("bp_y", 32'(pt_y), 31);
      check("bp_drop_v", 32'(drop_v), 0);
      check("bp_commit", 32'(commit), 0);
    end
    res_valid = 1'b0; res_inside = 1'b0; res_mask = '0;
    step();
    pt_ready = 1'b1;
    check("bp_valid6", 32'(pt_valid), 1);
    step();
    pt_ready = 1'b0;
    check("wait_valid", 32'(pt_valid), 0);
    check("wait_drop_v", 32'(drop_v), 0);

    // Inside result: only the new point is dropped.
    res_valid = 1'b1; res_inside = 1'b1; res_mask = 12'h804;
    step();
    res_valid = 1'b0; res_inside = 1'b0; res_mask = '0;
    check("in_drop_v", 32'(drop_v), 1);
    check("in_drop_x", 32'(drop_x), 992);
    check("in_drop_y", 32'(drop_y), 31);
    check("in_raddr", 32'(hull_raddr), 0);
    step();
    check("in_drop_v_off", 32'(drop_v), 0);
    check("in_commit", 32'(commit), 1);
    check("in_hold_x", 32'(drop_x), 992);
    step();
    check("in_commit_off", 32'(commit), 0);
    check("in_read_pt", 32'(read_pt), 1);

    // Mask serialisation over entries 2, 5, 11.
    feed(10'd100, 10'd200);
    check("m_pt_x", 32'(pt_x), 100);
    check("m_pt_y", 32'(pt_y), 200);
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    step();
    check("m_wait_commit", 32'(commit), 0);
    check("m_wait_drop_v", 32'(drop_v), 0);
    res_valid = 1'b1; res_mask = 12'b1000_0010_0100;
    step();
    res_valid = 1'b0; res_mask = '0;
    check("m0_v", 32'(drop_v), 1);
    check("m0_raddr", 32'(hull_raddr), 2);
    check("m0_x", 32'(drop_x), 10);
    check("m0_y", 32'(drop_y), 20);
    step();
    check("m1_v", 32'(drop_v), 1);
    check("m1_raddr", 32'(hull_raddr), 5);
    check("m1_x", 32'(drop_x), 30);
    check("m1_y", 32'(drop_y), 40);
    step();
    check("m2_v", 32'(drop_v), 1);
    check("m2_raddr", 32'(hull_raddr), 11);
    check("m2_x", 32'(drop_x), 50);
    check("m2_y", 32'(drop_y), 60);
    check("m2_commit", 32'(commit), 0);
    step();
    check("m_drop_v_off", 32'(drop_v), 0);
    check("m_commit", 32'(commit), 1);
    check("m_hold_x", 32'(drop_x), 50);
    check("m_hold_y", 32'(drop_y), 60);
    step();
    check("m_read_pt", 32'(read_pt), 1);

    // Zero mask: COMMIT right after the result, REQ right after that.
    feed(10'd7, 10'd9);
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    res_valid = 1'b1; res_mask = '0;
    step();
    res_valid = 1'b0;
    check("z_commit", 32'(commit), 1);
    check("z_drop_v", 32'(drop_v), 0);
    step();
    check("z_commit_off", 32'(commit), 0);
    check("z_read_pt", 32'(read_pt), 1);

    // Reset during the second drop cycle.
    feed(10'd5, 10'd6);
    pt_ready = 1'b1;
    step();
    pt_ready = 1'b0;
    res_valid = 1'b1; res_mask = 12'h003;
    step();
    res_valid = 1'b0; res_mask = '0;
    check("r0_raddr", 32'(hull_raddr), 0);
    check("r0_x", 32'(drop_x), 1);
    step();
    check("r1_v", 32'(drop_v), 1);
    check("r1_raddr", 32'(hull_raddr), 1);
    check("r1_x", 32'(drop_x), 3);
    #2 rst_n = 1'b0;
    #1;
    check("ra_drop_v", 32'(drop_v), 0);
    check("ra_commit", 32'(commit), 0);
    check("ra_raddr", 32'(hull_raddr), 0);
    check("ra_drop_x", 32'(drop_x), 0);
    check("ra_pt_x", 32'(pt_x), 0);
    check("ra_pt_valid", 32'(pt_valid), 0);
    step();
    check("ra_commit2", 32'(commit), 0);
    rst_n = 1'b1;
    check("rr_read_pt0", 32'(read_pt), 0);
    step();
    check("rr_read_pt1", 32'(read_pt), 1);
    step();
    check("rr_read_pt2", 32'(read_pt), 0);
    check("rr_commit", 32'(commit), 0);

    check("commit_count", 32'(commit_cnt), 3);
    check("read_pt_count", 32'(rp_cnt), 5);
    check("read_pt_consec", 32'(rp_consec), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/convex_ctrl.md
# convex_ctrl

Sequencing controller for the CONVEX incremental convex-hull design. It requests each new point from the external source over the READ_PT / PT_XY nibble stream and assembles the 10-bit X and Y coordinates. It then hands the point to the hull core and serialises the core's drop result onto DROP_X / DROP_Y / DROP_V, one point per cycle, before committing and requesting the next point. It sits between the chip pins and the hull datapath (hull storage plus orientation tests), and owns all handshakes on both sides.

## Interface
- MAXPT, 12: hull storage depth; width of the drop mask.
- COORD_W, 10: coordinate width.
- NIB_W, 5: PT_XY nibble width (COORD_W = 2*NIB_W).

- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- PT_XY  in  NIB_W  point nibble stream, in order X[9:5], X[4:0], Y[9:5], Y[4:0].
- READ_PT  out  1  one-cycle request for the next point.
- PT_X, PT_Y  out  COORD_W  assembled point to the core; held stable while PT_VALID.
- PT_VALID  out  1  point offered to the core.
- PT_READY  in  1  core accepts the point.
- RES_VALID  in  1  core result valid (single-cycle pulse).
- RES_INSIDE  in  1  new point lies inside or on the hull, so the new point itself is dropped.
- RES_MASK  in  MAXPT  hull entries dropped by the new point; bit i = hull index i.
- HULL_RADDR  out  4  read index into hull storage.
- HULL_X, HULL_Y  in  COORD_W  combinational read data for HULL_RADDR.
- COMMIT  out  1  one-cycle pulse; the core applies the update now.
- DROP_X, DROP_Y  out  COORD_W  dropped point.
- DROP_V  out  1  DROP_X/Y valid this cycle.

## Operation
- States: IDLE, REQ, LD0, LD1, LD2, LD3, ISSUE, WAIT, DROP, COMMIT.
- IDLE → REQ unconditionally (one cycle after reset release).
- REQ: READ_PT=1 for exactly one cycle → LD0.
- LD0..LD3: capture PT_XY at the end of each state into X_hi, X_lo, Y_hi, Y_lo. X = {X_hi, X_lo}, Y = {Y_hi, Y_lo}. No arithmetic; pure concatenation. → ISSUE.
- ISSUE: PT_VALID=1 with PT_X/PT_Y from the assembled point; leave on PT_VALID && PT_READY → WAIT.
- WAIT: on RES_VALID, latch RES_INSIDE and RES_MASK (bits ≥ MAXPT forced 0).
  - If RES_INSIDE → DROP, emitting the new point only; the mask is ignored.
  - Else if mask == 0 → COMMIT.
  - Else → DROP.
- DROP, mask mode: HULL_RADDR = lowest set bit. DROP_X/Y = HULL_X/Y, DROP_V=1. Clear that bit. Stay in DROP while the mask is nonzero after clearing, otherwise → COMMIT. Cycles spent = popcount(mask); drops are emitted in ascending index order.
- DROP, inside mode: DROP_X/Y = assembled point, DROP_V=1 for one cycle → COMMIT.
- COMMIT: COMMIT=1 for one cycle → REQ. The core must not modify hull storage before COMMIT.
- There is no end-of-stream; the controller loops until reset.

## Timing
- Reset values:
  - READ_PT, PT_VALID, COMMIT, DROP_V all 0.
  - PT_X, PT_Y, DROP_X, DROP_Y, HULL_RADDR all 0.
  - Internal mask and nibble registers 0; state IDLE.
- The nibble source samples READ_PT at edge t. X_hi is valid during the cycle after edge t and is captured at edge t+1; the remaining nibbles are captured at t+2, t+3, t+4.
- READ_PT is registered; it must never be 1 in two consecutive cycles.
- PT_VALID stays asserted and PT_X/PT_Y stay stable until PT_READY; there is no timeout.
- RES_VALID outside WAIT is ignored.
- PT_READY outside ISSUE is ignored.
- DROP_V cycles are contiguous. DROP_X/Y hold their last value when DROP_V=0.
- Minimum loop for a point with no drops: REQ(1) + LD(4) + ISSUE(1) + WAIT(core latency, ≥1) + COMMIT(1) = 8 cycles.
- Reset asserted mid-operation: all outputs clear asynchronously. Any partial point or pending mask is discarded, no COMMIT is issued, and the sequence restarts at IDLE.

## Structure
- Shared package convex_pkg:
  - constants MAXPT, COORD_W, NIB_W;
  - typedef point_t {x, y};
  - the state enum ctrl_state_e.
- Sub-module convex_pt_deser: the 4-nibble shift/assembly register, driven by a load-enable and a nibble-index from the FSM.
- The lowest-set-bit scan is an inline function in the package (lsb_idx).

## Test plan
- Nibble assembly: stream 0x1F,0x00,0x00,0x1F for point (992,31) → PT_X=992, PT_Y=31 at the first PT_VALID; READ_PT high exactly once.
- Inside point: RES_INSIDE=1, RES_MASK=12'h804 → one DROP_V cycle with (992,31), then COMMIT, then REQ; no hull reads.
- Mask serialise: RES_MASK=12'b1000_0010_0100, HULL entries 2,5,11 = (10,20),(30,40),(50,60) → three consecutive DROP_V cycles in index order 2,5,11, then COMMIT.
- Zero mask: RES_VALID with mask 0 → no DROP_V; COMMIT the cycle after RES_VALID; READ_PT the cycle after that.
- Backpressure: PT_READY low for 5 cycles → PT_VALID held 6 cycles with stable PT_X/Y; a spurious RES_VALID during ISSUE is ignored.
- Reset mid-DROP: RST_N low during the second drop cycle → DROP_V=0 immediately, no COMMIT; after release, READ_PT reasserts 2 cycles later.
